// File: rtl/cpu_defs.sv
// Shared definitions for the multiply/divide unit: FSM states and sizing.
package cpu_defs;

    // Default operand width; HI and LO are each this wide.
    localparam int MD_WIDTH = 32;

    // One Booth or restoring step per operand bit.
    localparam int MD_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_DIV    = 2'd2,
        ST_FINISH = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_restoring_core.sv
// One combinational restoring-division step on unsigned magnitudes.
// The partial remainder and the dividend/quotient register shift left together.
// The divisor is trial-subtracted, and the result is kept only if it is non-negative.
module div_restoring_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // The shifted remainder can reach 2*divisor-1, so one extra bit holds it and the borrow.
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, divisor_i};

    // Restore on borrow, otherwise commit the subtraction and shift in a quotient 1.
    always_comb begin
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiplier/divider owning the HI/LO registers.
//
//   state  | meaning
//   IDLE   | waiting for MultCtrl/DivCtrl; HI/LO hold
//   MULT   | one radix-2 Booth step per cycle
//   DIV    | one restoring step per cycle on magnitudes
//   FINISH | Done (and DivZero) pulse; HI/LO already hold the result
//
// HI/LO are committed on the edge that enters FINISH.
// This makes them valid during the whole Done cycle.
module mult_div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HIout,
    output logic [WIDTH-1:0] LOout,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    // Iterations track the operand width; the package count covers the default width.
    localparam int STEPS = (WIDTH == MD_WIDTH) ? MD_STEPS : WIDTH;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Upper accumulator carries one guard bit so that subtracting the most negative
    // multiplicand cannot overflow during Booth steps.
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             qm1_q, qm1_d;
    // Multiplicand for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [2*WIDTH:0] booth_shift;
    logic [WIDTH:0]   booth_hi;
    logic [WIDTH-1:0] booth_lo;

    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;

    assign mcand_ext = {opnd_q[WIDTH-1], opnd_q};

    // Booth recoding of {multiplier LSB, q_-1}: 01 adds, 10 subtracts the multiplicand.
    always_comb begin
        unique case ({acc_lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_hi_q + mcand_ext;
            2'b10:   booth_sum = acc_hi_q - mcand_ext;
            default: booth_sum = acc_hi_q;
        endcase
    end

    // Arithmetic right shift of {sum, multiplier}; the dropped LSB becomes the new q_-1.
    assign booth_shift = {booth_sum[WIDTH], booth_sum, acc_lo_q[WIDTH-1:1]};
    assign booth_hi    = booth_shift[2*WIDTH:WIDTH];
    assign booth_lo    = booth_shift[WIDTH-1:0];

    div_restoring_core #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (acc_hi_q[WIDTH-1:0]),
        .quo_i     (acc_lo_q),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Quotient truncates toward zero, and the remainder follows the dividend sign.
    // The most negative value divided by -1 wraps back to itself.
    assign quo_fix = quo_neg_q ? -div_quo : div_quo;
    assign rem_fix = rem_neg_q ? -div_rem : div_rem;

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        qm1_d     = qm1_q;
        opnd_d    = opnd_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (MultCtrl) begin
                    opnd_d   = A;
                    acc_hi_d = '0;
                    acc_lo_d = B;
                    qm1_d    = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_MULT;
                end else if (DivCtrl) begin
                    if (B == '0) begin
                        // No iterations; HI/LO keep their previous value.
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        opnd_d    = magnitude(B);
                        acc_hi_d  = '0;
                        acc_lo_d  = magnitude(A);
                        quo_neg_d = A[WIDTH-1] ^ B[WIDTH-1];
                        rem_neg_d = A[WIDTH-1];
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = ST_DIV;
                    end
                end
            end

            ST_MULT: begin
                acc_hi_d = booth_hi;
                acc_lo_d = booth_lo;
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    hi_d    = booth_hi[WIDTH-1:0];
                    lo_d    = booth_lo;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            ST_DIV: begin
                acc_hi_d = {1'b0, div_rem};
                acc_lo_d = div_quo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            qm1_q     <= 1'b0;
            opnd_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            qm1_q     <= qm1_d;
            opnd_q    <= opnd_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign HIout   = hi_q;
    assign LOout   = lo_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO/DivZero,
// and a negedge monitor pops and compares whenever Done is seen.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        MultCtrl;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HIout;
    logic [31:0] LOout;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MultCtrl (MultCtrl),
        .DivCtrl  (DivCtrl),
        .A        (A),
        .B        (B),
        .HIout    (HIout),
        .LOout    (LOout),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: each Done pops one expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.nm, "_hi"}, HIout, e.hi);
                chk({e.nm, "_lo"}, LOout, e.lo);
                chk({e.nm, "_divzero"}, {31'd0, DivZero}, {31'd0, e.dz});
            end
        end
    end

    // Issue one operation, then check its latency and Busy width against the protocol.
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input bit repulse, input string nm);
        exp_t e;
        int lat;
        int busy_n;
        int exp_lat;
        int exp_busy;
        e.hi = eh; e.lo = el; e.dz = edz; e.nm = nm;
        sb_q.push_back(e);
        exp_lat  = edz ? 1 : 33;
        exp_busy = edz ? 0 : 32;
        @(negedge clk);
        MultCtrl = m; DivCtrl = d; A = a; B = b;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0; DivCtrl = 1'b0;
        A = $urandom; B = $urandom;
        lat = 0; busy_n = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (Busy) busy_n++;
            if (repulse && lat == 10) begin
                MultCtrl = 1'b1; DivCtrl = 1'b1; A = 32'h1234_5678; B = 32'h0000_0003;
            end
            if (repulse && lat == 11) begin
                MultCtrl = 1'b0; DivCtrl = 1'b0;
            end
            if (Done) break;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, busy_n, exp_busy);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, Done}, 32'd0);
        chk({nm, "_hi_hold"}, HIout, eh);
    endtask

    initial begin
        reset = 1'b0; MultCtrl = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
        #12;
        chk("rst_hi", HIout, 32'd0);
        chk("rst_lo", LOout, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_divzero", {31'd0, DivZero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(1, 0, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 0, 0, "mul_7x6");
        do_op(1, 0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0, 0, "mul_m1xmin");
        do_op(0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, "div_m7d2");
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0, "div_minxm1");
        do_op(0, 1, 32'h0000_1234, 32'd0,         32'h0000_0000, 32'h8000_0000, 1, 0, "div_zero_a");
        do_op(1, 1, 32'd100,       32'd7,         32'h0000_0000, 32'h0000_02BC, 0, 0, "both_ctrl");
        do_op(1, 0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 1, "mul_repulse");
        do_op(0, 1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0, "div_7dm2");
        do_op(0, 1, 32'hFFFF_FFFF, 32'd0,         32'h0000_0001, 32'hFFFF_FFFD, 1, 0, "div_zero_b");
        do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, "mul_minxmin");

        // Abort a multiply at iteration 15 with reset.
        @(negedge clk);
        MultCtrl = 1'b1; A = 32'h0001_0000; B = 32'h0001_0000;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_abort_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_hi", HIout, 32'd0);
        chk("abort_lo", LOout, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 0, "mul_after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
